// File: rtl/bist_sequencer.sv
// BIST run-control sequencer: seeds TPG/MISR, applies npat patterns,
// flushes the CUT pipeline and grades the MISR signature.
module bist_sequencer #(
  parameter int NPAT_W = 8,
  parameter int SIG_W  = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [NPAT_W-1:0] npat,
  input  logic [SIG_W-1:0]  golden,
  input  logic [SIG_W-1:0]  signature,
  output logic              bist_mode,
  output logic              tpg_init,
  output logic              misr_init,
  output logic              tpg_en,
  output logic              misr_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              bist_end
);

  localparam int DW = (LAT > 0) ? LAT : 1;
  localparam logic [2:0] FL_LAST =
    (LAT > 0) ? 3'(LAT - 1) : 3'd0;
  localparam logic [NPAT_W-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_CMP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NPAT_W-1:0] cnt_q, cnt_d;
  logic [NPAT_W-1:0] npat_q, npat_d;
  logic [SIG_W-1:0]  gold_q, gold_d;
  logic [2:0]        fl_q, fl_d;
  logic [DW-1:0]     dl_q, dl_d;

  logic mode_q, mode_d;
  logic init_q, init_d;
  logic ten_q, ten_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic end_q, end_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    npat_d  = npat_q;
    gold_d  = gold_q;
    fl_d    = fl_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    end_d   = end_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_INIT;
          npat_d  = npat;
          gold_d  = golden;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          end_d   = 1'b0;
        end
      end
      S_INIT: begin
        cnt_d = '0;
        fl_d  = '0;
        if (npat_q != '0) begin
          state_d = S_RUN;
        end else if (LAT > 0) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_CMP;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == npat_q - ONE) begin
          state_d = (LAT > 0) ? S_FLUSH : S_CMP;
        end
      end
      S_FLUSH: begin
        fl_d = fl_q + 3'd1;
        if (fl_q == FL_LAST) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        pass_d  = (signature == gold_q);
        fail_d  = (signature != gold_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort wins over every in-flight transition, including the grade
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pass_d  = pass_q;
      fail_d  = fail_q;
    end

    mode_d = state_d inside {S_INIT, S_RUN, S_FLUSH, S_CMP};
    init_d = (state_d == S_INIT);
    ten_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      end_d = 1'b1;
    end

    dl_d[0] = ten_q;
    for (int k = 1; k < DW; k++) begin
      dl_d[k] = dl_q[k-1];
    end
    if (state_d inside {S_IDLE, S_INIT}) begin
      dl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      npat_q  <= '0;
      gold_q  <= '0;
      fl_q    <= '0;
      dl_q    <= '0;
      mode_q  <= 1'b0;
      init_q  <= 1'b0;
      ten_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      gold_q  <= gold_d;
      fl_q    <= fl_d;
      dl_q    <= dl_d;
      mode_q  <= mode_d;
      init_q  <= init_d;
      ten_q   <= ten_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      end_q   <= end_d;
    end
  end

  assign bist_mode = mode_q;
  assign tpg_init  = init_q;
  assign misr_init = init_q;
  assign tpg_en    = ten_q;
  assign misr_en   = (LAT == 0) ? ten_q : dl_q[DW-1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign bist_end  = end_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: two instances (LAT=2, LAT=0)
// against a phase-arithmetic reference model.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        st[2];
  logic        ab[2];
  logic [7:0]  npi[2];
  logic [15:0] gdi[2];
  logic [15:0] sgi[2];
  logic [15:0] plan[2];

  logic [9:0] o0, o1;

  int          p[2];
  int          nl[2];
  logic [15:0] gl[2];
  bit          eps[2], efl[2], ebe[2];

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bist_sequencer #(.NPAT_W(8), .SIG_W(16), .LAT(2)) u0 (
    .clk(clk), .reset(reset),
    .start(st[0]), .abort(ab[0]),
    .npat(npi[0]), .golden(gdi[0]), .signature(sgi[0]),
    .bist_mode(o0[0]), .tpg_init(o0[1]), .misr_init(o0[2]),
    .tpg_en(o0[3]), .misr_en(o0[4]), .busy(o0[5]),
    .done(o0[6]), .pass(o0[7]), .fail(o0[8]), .bist_end(o0[9])
  );

  bist_sequencer #(.NPAT_W(8), .SIG_W(16), .LAT(0)) u1 (
    .clk(clk), .reset(reset),
    .start(st[1]), .abort(ab[1]),
    .npat(npi[1]), .golden(gdi[1]), .signature(sgi[1]),
    .bist_mode(o1[0]), .tpg_init(o1[1]), .misr_init(o1[2]),
    .tpg_en(o1[3]), .misr_en(o1[4]), .busy(o1[5]),
    .done(o1[6]), .pass(o1[7]), .fail(o1[8]), .bist_end(o1[9])
  );

  function automatic int lat(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Expected outputs from cycles elapsed since the start was accepted
  function automatic logic [9:0] exp_o(int ph, int n, int lt,
                                       bit ps, bit fl, bit be);
    int d;
    logic bm, ti, te, me, bz, dn;
    d  = 3 + n + lt;
    bm = (ph >= 1) && (ph <= d - 1);
    ti = (ph == 1);
    te = (ph >= 2) && (ph <= 1 + n);
    me = (ph >= 2 + lt) && (ph <= 1 + n + lt);
    bz = (ph >= 1) && (ph <= d);
    dn = (ph == d);
    return {be, fl, ps, dn, bz, me, te, ti, ti, bm};
  endfunction

  task automatic chk(string nm, int i, logic [15:0] a, logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h",
               nm, i, $time, a, e);
    end
  endtask

  task automatic push(int i, logic [1:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic cancel(int i);
    if (i == 0 && q0.size() > 0) void'(q0.pop_back());
    if (i == 1 && q1.size() > 0) void'(q1.pop_back());
  endtask

  task automatic sb_pop(int i, logic [1:0] got);
    int sz;
    logic [1:0] e;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL verdict dut%0d t=%0t actual=done required=no_run",
               i, $time);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk("verdict", i, 16'(got), 16'(e));
    end
  endtask

  // Reference model: phase 0 = idle, 1 = INIT, ... 3+npat+LAT = DONE
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        p[i] = 0;
        eps[i] = 0;
        efl[i] = 0;
        ebe[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int d;
        d = 3 + nl[i] + lat(i);
        if (p[i] == 0) begin
          if (st[i] && !ab[i]) begin
            p[i] = 1;
            nl[i] = int'(npi[i]);
            gl[i] = gdi[i];
            eps[i] = 0;
            efl[i] = 0;
            ebe[i] = 0;
          end
        end else if (ab[i]) begin
          if (p[i] < d) cancel(i);
          p[i] = 0;
        end else begin
          if (p[i] == d - 1) begin
            eps[i] = (sgi[i] == gl[i]);
            efl[i] = (sgi[i] != gl[i]);
            ebe[i] = 1;
          end
          p[i] = (p[i] == d) ? 0 : p[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    logic [9:0] a, e;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? o0 : o1;
      e = reset ? exp_o(p[i], nl[i], lat(i), eps[i], efl[i], ebe[i])
                : 10'd0;
      chk("outputs", i, 16'(a), 16'(e));
      if (reset && a[6]) sb_pop(i, {a[7], a[8]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int i, bit s_, bit a_, logic [7:0] n,
                        logic [15:0] g, logic [15:0] s);
    st[i] = s_;
    ab[i] = a_;
    npi[i] = n;
    gdi[i] = g;
    if (p[i] == 0 && s_ && !a_) begin
      plan[i] = s;
      push(i, {s == g, s != g});
    end
    sgi[i] = (p[i] != 0 || (s_ && !a_)) ? plan[i] : s;
  endtask

  task automatic set_idle(int i);
    set_in(i, 0, 0, 8'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic run_dir(int i, int n, logic [15:0] g, logic [15:0] s,
                         int ab_at, int rs_at);
    int guard;
    set_in(i, 1, 0, 8'(n), g, s);
    tick();
    guard = 0;
    while (p[i] != 0 && guard < 400) begin
      set_in(i, p[i] == rs_at, p[i] == ab_at,
             8'($urandom), 16'($urandom), s);
      tick();
      guard++;
    end
    if (p[i] != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout dut%0d actual=busy required=idle", i);
    end
    set_idle(i);
    tick();
    tick();
  endtask

  initial begin
    int guard;
    logic [15:0] g;
    for (int i = 0; i < 2; i++) begin
      p[i] = 0; nl[i] = 0; gl[i] = '0;
      eps[i] = 0; efl[i] = 0; ebe[i] = 0;
      st[i] = 0; ab[i] = 0; npi[i] = '0;
      gdi[i] = '0; sgi[i] = '0; plan[i] = '0;
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    set_idle(0);
    set_idle(1);
    tick();

    run_dir(0, 5, 16'hA5C3, 16'hA5C3, -1, -1);
    run_dir(0, 3, 16'h1234, 16'h1235, -1, -1);
    repeat (3) tick();
    run_dir(1, 0, 16'h0F0F, 16'h0F0F, -1, -1);
    run_dir(0, 10, 16'hBEEF, 16'hBEEF, 4, -1);
    run_dir(0, 6, 16'h5555, 16'h5555, -1, -1);
    set_in(0, 1, 1, 8'd4, 16'h1111, 16'h1111);
    set_in(1, 1, 1, 8'd4, 16'h2222, 16'h2222);
    tick();
    set_idle(0);
    set_idle(1);
    tick();
    run_dir(0, 4, 16'hC0DE, 16'hC0DE, -1, 3);
    run_dir(1, 3, 16'h7777, 16'h7776, -1, 2);
    run_dir(1, 7, 16'h0001, 16'h0001, 5, -1);

    // asynchronous reset in the middle of FLUSH
    g = 16'($urandom);
    set_in(0, 1, 0, 8'd3, g, g);
    tick();
    guard = 0;
    while (p[0] != 5 && guard < 50) begin
      set_idle(0);
      tick();
      guard++;
    end
    #2 reset = 1'b0;
    #1;
    chk("async_reset", 0, 16'(o0), 16'd0);
    chk("async_reset", 1, 16'(o1), 16'd0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      st[i] = 0;
      ab[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();
    run_dir(0, 4, 16'h9999, 16'h9999, -1, -1);

    // randomized traffic on both instances
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] n;
        logic [15:0] gg, ss;
        gg = 16'($urandom);
        if ($urandom_range(0, 20) == 0) n = 8'($urandom_range(0, 40));
        else if ($urandom_range(0, 4) == 0) n = 8'd0;
        else n = 8'($urandom_range(1, 12));
        if (p[i] == 0) begin
          ss = $urandom_range(0, 1) ? gg
               : gg ^ (16'd1 << $urandom_range(0, 15));
          set_in(i, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, n, gg, ss);
        end else begin
          set_in(i, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0, n, gg, 16'($urandom));
        end
      end
      tick();
    end

    for (int i = 0; i < 2; i++) set_in(i, 0, 0, 8'd0, 16'd0, 16'd0);
    repeat (60) tick();
    chk("sb_drain", 0, 16'(q0.size()), 16'd0);
    chk("sb_drain", 1, 16'(q1.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
